mdu_iter: RTL and testbench

Parametrised multiply/divide unit for the EX stage, successor to the fixed-latency 32-bit MDU. Multiplies complete after a configurable pipeline delay. Division is a real iterative restoring divider, one quotient bit per cycle, so busy reflects actual work. Adds a start/busy/done handshake, a cancel input for exception flushes, and a divide-by-zero flag. HI/LO are architectural and change only on completion or on MTHI/MTLO.

---
 rtl/mdu_iter.sv | 205 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Multiply/divide unit: pipelined-latency multiply class and an iterative
// restoring divider (one quotient bit per cycle) writing architectural HI/LO.
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2      = 2 * WIDTH;
    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DPREP,
        S_DITER,
        S_DFIX
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    logic              op_uns;
    logic [W2-1:0]     a_ext, b_ext, mul_raw, hilo, mul_res;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    rem_sh, rem_diff;
    logic [WIDTH-1:0]  quo_fix, rem_fix;

    // op[0] selects unsigned for every multiply and divide opcode.
    assign op_uns  = op[0];
    assign a_ext   = op_uns ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext   = op_uns ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    assign mul_raw = a_ext * b_ext;
    assign hilo    = {hi_q, lo_q};

    always_comb begin
        mul_res = mul_raw;
        case (op[2:1])
            2'b10:   mul_res = hilo + mul_raw;
            2'b11:   mul_res = hilo - mul_raw;
            default: mul_res = mul_raw;
        endcase
    end

    assign a_neg = !op_uns && a[WIDTH-1];
    assign b_neg = !op_uns && b[WIDTH-1];
    assign a_mag = a_neg ? ({WIDTH{1'b0}} - a) : a;
    assign b_mag = b_neg ? ({WIDTH{1'b0}} - b) : b;

    // A negative trial difference shows up as a set top bit of the (W+1)-bit result.
    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};

    assign quo_fix = negq_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
    assign rem_fix = negr_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        if (state_q != S_IDLE && cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                                prod_d  = mul_res;
                                cnt_d   = MUL_INIT;
                                state_d = S_MUL;
                            end
                            4'd2, 4'd3: begin
                                if (b == '0) begin
                                    done_d = 1'b1;
                                    dz_d   = 1'b1;
                                end else begin
                                    quo_d   = a_mag;
                                    dvs_d   = b_mag;
                                    rem_d   = '0;
                                    negq_d  = a_neg ^ b_neg;
                                    negr_d  = a_neg;
                                    state_d = S_DPREP;
                                end
                            end
                            4'd8:    hi_d = a;
                            4'd9:    lo_d = a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        hi_d    = prod_q[W2-1:WIDTH];
                        lo_d    = prod_q[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_DPREP: begin
                    cnt_d   = DIV_INIT;
                    state_d = S_DITER;
                end
                S_DITER: begin
                    if (!rem_diff[WIDTH]) begin
                        rem_d = rem_diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = S_DFIX;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_DFIX: begin
                    lo_d    = quo_fix;
                    hi_d    = rem_fix;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: multiply/divide results, latency, div-by-zero,
// cancel, reset mid-operation and back-to-back issue.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cancel = 1'b0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int n, bc, ev;

    mdu_iter #(.WIDTH(W), .MUL_LAT(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    // Returns edges after E0 until done is seen, and cycles with busy high.
    task automatic wait_done(input int max, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (cyc < max) begin
            if (done) break;
            if (busy) bcnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int exp_n,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cyc, bcnt;
        issue(o, x, y);
        wait_done(60, cyc, bcnt);
        check({tag, "_lat"}, 64'(cyc), 64'(exp_n));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_n));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_dz"}, 64'(div_zero), 64'd0);
        check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        reset = 1'b0;
        check("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        // Multiply and divide results with latency
        run_op("mult_neg",  4'd0, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("divu",      4'd3, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        run_op("div_neg",   4'd2, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_minm1", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);

        // MTHI/MTLO then accumulate forms
        issue(4'd8, 32'd0, 32'd0);
        check("mthi_flags", {62'd0, busy, done}, 64'd0);
        issue(4'd9, 32'd10, 32'd0);
        check("mtlo_hilo", {hi, lo}, {32'd0, 32'd10});
        check("mtlo_flags", {62'd0, busy, done}, 64'd0);
        run_op("maddu", 4'd5, 32'd3, 32'd4, 5, 32'd0, 32'd22);
        run_op("msub",  4'd6, 32'd1, 32'd23, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // NOP opcode leaves everything alone
        issue(4'd12, 32'd5, 32'd5);
        check("nop_flags", {62'd0, busy, done}, 64'd0);
        tick();
        check("nop_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Divide by zero
        issue(4'd8, 32'h11, 32'd0);
        issue(4'd9, 32'h22, 32'd0);
        issue(4'd2, 32'd5, 32'd0);
        check("dz_flags", {61'd0, busy, done, div_zero}, 64'd3);
        check("dz_hilo", {hi, lo}, {32'h11, 32'h22});
        tick();
        check("dz_pulse", {61'd0, busy, done, div_zero}, 64'd0);

        // Cancel an in-flight DIVU at E0+10
        issue(4'd3, 32'd100, 32'd7);
        repeat (9) tick();
        check("cancel_pre_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        start  = 1'b1;
        op     = 4'd9;
        a      = 32'h55;
        tick();
        cancel = 1'b0;
        check("cancel_flags", {62'd0, busy, done}, 64'd0);
        check("cancel_hilo", {hi, lo}, {32'h11, 32'h22});
        tick();
        start = 1'b0;
        check("after_cancel_accept", 64'(lo), 64'h55);
        cancel = 1'b1;
        start  = 1'b1;
        op     = 4'd8;
        a      = 32'h99;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_idle_block", 64'(hi), 64'h11);
        ev = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) ev++;
            tick();
        end
        check("cancel_no_done", 64'(ev), 64'd0);

        // Reset in the middle of a MULT, after an ignored start
        issue(4'd0, 32'd2, 32'd3);
        tick();
        start = 1'b1;
        op    = 4'd3;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        check("ignored_start_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        check("midrst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        ev = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) ev++;
            tick();
        end
        check("midrst_quiet", 64'(ev), 64'd0);
        check("midrst_hilo_after", {hi, lo}, 64'd0);

        // Back-to-back MULTs, second start in the done cycle
        issue(4'd0, 32'd6, 32'd7);
        wait_done(60, n, bc);
        check("b2b1_lat", 64'(n), 64'd5);
        check("b2b1_hilo", {hi, lo}, {32'd0, 32'd42});
        start = 1'b1;
        op    = 4'd0;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        check("b2b_accept", 64'(busy), 64'd1);
        wait_done(60, n, bc);
        check("b2b2_lat", 64'(n), 64'd5);
        check("b2b2_hilo", {hi, lo}, {32'd0, 32'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
